updown_sweep_ctrl: RTL and testbench

- Sequencer for the team's 8-bit up/down counter (`counter8b_updown`).
- Drives the counter's direction, enable and load controls so the count sweeps as a triangle between programmable lower and upper limits, for a programmed number of round trips or continuously.
- Watches the counter's `count` output to decide when to turn around.
- Sits between a host or config interface and the counter.

---
 rtl/updown_sweep_ctrl_if.sv | 31 +++
 rtl/updown_sweep_ctrl.sv | 141 ++++++++++++++
 tb/tb_updown_sweep_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/updown_sweep_ctrl_if.sv
// Host/counter-side signal bundle for the up/down sweep sequencer.
// The master side drives the requests and the counter's count; the slave side is the sequencer.
interface updown_sweep_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CYC_W = 4
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [CYC_W-1:0] cycles;
  logic [WIDTH-1:0] count;
  logic             cnt_en;
  logic             cnt_dir;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_load_val;
  logic             busy;
  logic             done;
  logic             err;
  logic [CYC_W-1:0] sweep_cnt;

  modport master (
    output start, abort, lo, hi, cycles, count,
    input  cnt_en, cnt_dir, cnt_load, cnt_load_val, busy, done, err, sweep_cnt
  );

  modport slave (
    input  start, abort, lo, hi, cycles, count,
    output cnt_en, cnt_dir, cnt_load, cnt_load_val, busy, done, err, sweep_cnt
  );
endinterface

// File: rtl/updown_sweep_ctrl.sv
// Sequences an external 8-bit up/down counter through triangle sweeps between
// latched lo/hi limits, for a programmed number of round trips or continuously.
module updown_sweep_ctrl #(
  parameter int WIDTH = 8,
  parameter int CYC_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  updown_sweep_ctrl_if.slave  io_bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [CYC_W-1:0] r_cycles;
  logic [CYC_W-1:0] r_sweep_cnt;
  logic             r_err;

  logic             w_busy;
  logic             w_accept;
  logic             w_reject;
  logic             w_at_lo;
  logic             w_at_hi;
  logic [CYC_W-1:0] w_sweep_inc;
  logic             w_sweep_more;
  logic             w_sweep_tick;
  logic             w_abort;
  logic             w_cnt_en;
  logic             w_cnt_dir;
  logic             w_cnt_load;

  assign w_busy   = (r_state == S_LOAD) || (r_state == S_UP) || (r_state == S_DOWN);
  assign w_abort  = io_bus.abort && w_busy;
  assign w_accept = (r_state == S_IDLE) && io_bus.start && (io_bus.lo <  io_bus.hi);
  assign w_reject = (r_state == S_IDLE) && io_bus.start && (io_bus.lo >= io_bus.hi);
  assign w_at_lo  = (io_bus.count == r_lo);
  assign w_at_hi  = (io_bus.count == r_hi);

  // A round trip completes when the down leg reaches lo; cycles == 0 never completes.
  assign w_sweep_inc  = r_sweep_cnt + CYC_W'(1);
  assign w_sweep_more = (r_cycles == '0) || (w_sweep_inc < r_cycles);
  assign w_sweep_tick = (r_state == S_DOWN) && w_at_lo && !w_abort;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next     = r_state;
    w_cnt_en   = 1'b0;
    w_cnt_dir  = 1'b1;
    w_cnt_load = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_cnt_load = 1'b1;
        w_next     = S_UP;
      end
      S_UP: begin
        w_cnt_en = 1'b1;
        if (w_at_hi) begin
          w_cnt_dir = 1'b0;
          w_next    = S_DOWN;
        end
      end
      S_DOWN: begin
        w_cnt_en = 1'b1;
        if (!w_at_lo) begin
          w_cnt_dir = 1'b0;
        end else if (w_sweep_more) begin
          w_next = S_UP;
        end else begin
          w_cnt_en = 1'b0;
          w_next   = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    // Abort gates the counter in the same cycle and overrides any transition.
    if (w_abort) begin
      w_cnt_en   = 1'b0;
      w_cnt_load = 1'b0;
      w_next     = S_IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lo        <= '0;
      r_hi        <= '0;
      r_cycles    <= '0;
      r_sweep_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_lo        <= io_bus.lo;
        r_hi        <= io_bus.hi;
        r_cycles    <= io_bus.cycles;
        r_sweep_cnt <= '0;
        r_err       <= 1'b0;
      end else begin
        if (w_reject)     r_err       <= 1'b1;
        if (w_sweep_tick) r_sweep_cnt <= w_sweep_inc;
      end
    end
  end

  assign io_bus.cnt_en       = w_cnt_en;
  assign io_bus.cnt_dir      = w_cnt_dir;
  assign io_bus.cnt_load     = w_cnt_load;
  assign io_bus.cnt_load_val = r_lo;
  assign io_bus.busy         = w_busy;
  assign io_bus.done         = (r_state == S_DONE);
  assign io_bus.err          = r_err;
  assign io_bus.sweep_cnt    = r_sweep_cnt;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl: vector table for a full two-trip sweep and
// the rejected-start path, plus sequences for the wide sweep, abort and mid-sweep events.
module tb_updown_sweep_ctrl;
  localparam int WIDTH = 8;
  localparam int CYC_W = 4;

  typedef struct {
    logic             start;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [CYC_W-1:0] cyc;
    logic [WIDTH-1:0] count;
    logic             en;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             busy;
    logic             done;
    logic             err;
    logic [CYC_W-1:0] sweep;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [WIDTH-1:0] r_count = '0;
  int n_vec = 0;
  int n_miss = 0;
  vec_t vt[$];
  logic [WIDTH-1:0] exp_seq [6];

  always #5 clk = ~clk;

  updown_sweep_ctrl_if #(.WIDTH(WIDTH), .CYC_W(CYC_W)) bus();

  updown_sweep_ctrl #(.WIDTH(WIDTH), .CYC_W(CYC_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus.slave)
  );

  // Model of the external up/down counter; it has no reset of its own here.
  always @(posedge clk) begin
    if (bus.cnt_load)    r_count <= bus.cnt_load_val;
    else if (bus.cnt_en) r_count <= bus.cnt_dir ? r_count + 8'd1 : r_count - 8'd1;
  end
  assign bus.count = r_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [7:0] lo, input logic [7:0] hi,
                              input logic [3:0] cyc, input logic [7:0] cnt, input logic en,
                              input logic dir, input logic ld, input logic [7:0] lv,
                              input logic bsy, input logic dn, input logic er,
                              input logic [3:0] sw);
    vec_t v;
    v.start = st; v.lo = lo; v.hi = hi; v.cyc = cyc; v.count = cnt; v.en = en;
    v.dir = dir; v.load = ld; v.load_val = lv; v.busy = bsy; v.done = dn;
    v.err = er; v.sweep = sw;
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag, input logic [7:0] lv);
    check({tag, " en"},       bus.cnt_en, 0);
    check({tag, " dir"},      bus.cnt_dir, 1);
    check({tag, " load"},     bus.cnt_load, 0);
    check({tag, " load_val"}, bus.cnt_load_val, lv);
    check({tag, " busy"},     bus.busy, 0);
    check({tag, " done"},     bus.done, 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.lo = '0; bus.hi = '0; bus.cycles = '0;
    exp_seq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2};

    // lo=3 hi=6 cycles=2 full run, then rejected start lo=hi=6, then lo=3 hi=4 cycles=1.
    //           st lo hi cy cnt en dr ld lv by dn er sw
    vt.push_back(mk(1, 3, 6, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 3, 6, 2, 0, 0, 1, 1, 3, 1, 0, 0, 0));
    vt.push_back(mk(0, 3, 6, 2, 3, 1, 1, 0, 3, 1, 0, 0, 0));
    vt.push_back(mk(0, 3, 6, 2, 4, 1, 1, 0, 3, 1, 0, 0, 0));
    vt.push_back(mk(0, 3, 6, 2, 5, 1, 1, 0, 3, 1, 0, 0, 0));
    vt.push_back(mk(0, 3, 6, 2, 6, 1, 0, 0, 3, 1, 0, 0, 0));
    vt.push_back(mk(0, 3, 6, 2, 5, 1, 0, 0, 3, 1, 0, 0, 0));
    vt.push_back(mk(0, 3, 6, 2, 4, 1, 0, 0, 3, 1, 0, 0, 0));
    vt.push_back(mk(0, 3, 6, 2, 3, 1, 1, 0, 3, 1, 0, 0, 0));
    vt.push_back(mk(0, 3, 6, 2, 4, 1, 1, 0, 3, 1, 0, 0, 1));
    vt.push_back(mk(0, 3, 6, 2, 5, 1, 1, 0, 3, 1, 0, 0, 1));
    vt.push_back(mk(0, 3, 6, 2, 6, 1, 0, 0, 3, 1, 0, 0, 1));
    vt.push_back(mk(0, 3, 6, 2, 5, 1, 0, 0, 3, 1, 0, 0, 1));
    vt.push_back(mk(0, 3, 6, 2, 4, 1, 0, 0, 3, 1, 0, 0, 1));
    vt.push_back(mk(0, 3, 6, 2, 3, 0, 1, 0, 3, 1, 0, 0, 1));
    vt.push_back(mk(0, 3, 6, 2, 3, 0, 1, 0, 3, 0, 1, 0, 2));
    vt.push_back(mk(0, 3, 6, 2, 3, 0, 1, 0, 3, 0, 0, 0, 2));
    vt.push_back(mk(1, 6, 6, 2, 3, 0, 1, 0, 3, 0, 0, 0, 2));
    vt.push_back(mk(0, 6, 6, 2, 3, 0, 1, 0, 3, 0, 0, 1, 2));
    vt.push_back(mk(0, 6, 6, 2, 3, 0, 1, 0, 3, 0, 0, 1, 2));
    vt.push_back(mk(1, 3, 4, 1, 3, 0, 1, 0, 3, 0, 0, 1, 2));
    vt.push_back(mk(0, 3, 4, 1, 3, 0, 1, 1, 3, 1, 0, 0, 0));
    vt.push_back(mk(0, 3, 4, 1, 3, 1, 1, 0, 3, 1, 0, 0, 0));
    vt.push_back(mk(0, 3, 4, 1, 4, 1, 0, 0, 3, 1, 0, 0, 0));
    vt.push_back(mk(0, 3, 4, 1, 3, 0, 1, 0, 3, 1, 0, 0, 0));
    vt.push_back(mk(0, 3, 4, 1, 3, 0, 1, 0, 3, 0, 1, 0, 1));
    vt.push_back(mk(0, 3, 4, 1, 3, 0, 1, 0, 3, 0, 0, 0, 1));

    // Reset state, during and after reset.
    #3;
    check_idle_outputs("rst", 8'd0);
    check("rst err", bus.err, 0);
    check("rst sweep", bus.sweep_cnt, 0);
    #9 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("post-rst", 8'd0);
    check("post-rst err", bus.err, 0);
    check("post-rst sweep", bus.sweep_cnt, 0);

    // Vector table.
    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk); #1;
      bus.start = vt[i].start; bus.lo = vt[i].lo; bus.hi = vt[i].hi; bus.cycles = vt[i].cyc;
      @(negedge clk);
      check($sformatf("v%0d count", i),    bus.count,        vt[i].count);
      check($sformatf("v%0d en", i),       bus.cnt_en,       vt[i].en);
      check($sformatf("v%0d dir", i),      bus.cnt_dir,      vt[i].dir);
      check($sformatf("v%0d load", i),     bus.cnt_load,     vt[i].load);
      check($sformatf("v%0d load_val", i), bus.cnt_load_val, vt[i].load_val);
      check($sformatf("v%0d busy", i),     bus.busy,         vt[i].busy);
      check($sformatf("v%0d done", i),     bus.done,         vt[i].done);
      check($sformatf("v%0d err", i),      bus.err,          vt[i].err);
      check($sformatf("v%0d sweep", i),    bus.sweep_cnt,    vt[i].sweep);
    end

    // Full-range sweep 0..255..0, one round trip: no wrap at either end.
    begin
      int steps = 0;
      logic [7:0] prev = 8'd3;
      logic [7:0] after_top = 8'd0;
      logic [7:0] top = 8'd0;
      bit seen_done = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.lo = 8'd0; bus.hi = 8'd255; bus.cycles = 4'd1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int c = 0; c < 600 && !seen_done; c++) begin
        @(negedge clk);
        if (bus.done) begin
          seen_done = 1'b1;
        end else begin
          if (bus.cnt_en) steps++;
          if (bus.count > top) top = bus.count;
          if (prev == 8'hff && bus.count != 8'hff) after_top = bus.count;
          prev = bus.count;
        end
      end
      check("wide done seen", seen_done, 1);
      check("wide steps", steps, 510);
      check("wide top", top, 255);
      check("wide after top", after_top, 254);
      check("wide final count", bus.count, 0);
      check("wide sweep", bus.sweep_cnt, 1);
    end

    // Continuous sweep lo=10 hi=12, aborted after 7 steps.
    begin
      int steps = 0;
      bit aborted = 1'b0;
      bit done_seen = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.lo = 8'd10; bus.hi = 8'd12; bus.cycles = 4'd0;
      for (int c = 0; c < 40 && !aborted; c++) begin
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (steps == 7) bus.abort = 1'b1;
        @(negedge clk);
        if (bus.done) done_seen = 1'b1;
        if (bus.abort) begin
          aborted = 1'b1;
          check("abort en", bus.cnt_en, 0);
          check("abort load", bus.cnt_load, 0);
          check("abort count", bus.count, 11);
          check("abort sweep", bus.sweep_cnt, 1);
        end else if (bus.cnt_en) begin
          steps++;
        end
      end
      check("abort reached", aborted, 1);
      @(posedge clk); #1;
      bus.abort = 1'b0;
      @(negedge clk);
      check("post-abort busy", bus.busy, 0);
      check("post-abort done", bus.done, 0);
      check("post-abort en", bus.cnt_en, 0);
      @(negedge clk);
      if (bus.done) done_seen = 1'b1;
      check("abort done never", done_seen, 0);
      check("post-abort count hold", bus.count, 11);
    end

    // lo=1 hi=4 cycles=3: start re-pulsed while busy, then reset mid-DOWN.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.lo = 8'd1; bus.hi = 8'd4; bus.cycles = 4'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("mid load", bus.cnt_load, 1);
    check("mid load_val", bus.cnt_load_val, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      bus.start = (i == 1);
      bus.lo = (i == 1) ? 8'd0 : 8'd1;
      bus.hi = (i == 1) ? 8'd9 : 8'd4;
      @(negedge clk);
      check($sformatf("mid s%0d count", i), bus.count, exp_seq[i]);
      check($sformatf("mid s%0d busy", i), bus.busy, 1);
      check($sformatf("mid s%0d load", i), bus.cnt_load, 0);
    end
    check("mid load_val kept", bus.cnt_load_val, 1);
    #2 reset = 1'b0;
    #1;
    check_idle_outputs("async rst", 8'd0);
    check("async rst sweep", bus.sweep_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("after rst", 8'd0);
    check("after rst count hold", bus.count, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
